// File: rtl/crc_pkg.sv
// Shared types and bit-level helpers for the streaming CRC engine.
// Helpers work on a 64-bit container so that one definition serves every CRC width.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] crc_word_t;

    function automatic crc_word_t width_mask(input int width);
        crc_word_t m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                m = {m[MAX_W-2:0], 1'b1};
            end
        end
        return m;
    endfunction

    // One LFSR step: the feedback taps are the CRC's top bit XORed with the incoming bit.
    function automatic crc_word_t crc_step(input crc_word_t lfsr, input logic data_bit,
                                           input int width, input crc_word_t poly);
        crc_word_t top;
        logic      fb;
        top = lfsr >> (width - 1);
        fb  = top[0] ^ data_bit;
        return ((lfsr << 1) ^ (fb ? poly : '0)) & width_mask(width);
    endfunction

    function automatic crc_word_t bitrev(input crc_word_t value, input int width);
        crc_word_t src;
        crc_word_t rev;
        src = value;
        rev = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                rev = {rev[MAX_W-2:0], src[0]};
                src = src >> 1;
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/crc_stream_if.sv
// Framed input stream plus registered result port of one CRC engine instance.
interface crc_stream_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic              crc_valid;
    logic              crc_ready;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_match;
    logic              frame_err;

    modport master (
        output in_valid, in_data, in_sop, in_eop, crc_ready,
        input  in_ready, crc_valid, crc_out, crc_match, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, crc_ready,
        output in_ready, crc_valid, crc_out, crc_match, frame_err
    );

endinterface

// File: rtl/crc_next_comb.sv
// Combinational unroll of DATA_W serial LFSR steps, i.e. the CRC update for one beat.
module crc_next_comb
    import crc_pkg::*;
#(
    parameter int               CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = 16'h1021,
    parameter int               DATA_W     = 8,
    parameter bit               REFLECT_IN = 1'b0
) (
    input  logic [CRC_W-1:0]  lfsr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  lfsr_o
);

    crc_word_t acc;
    logic      data_bit;

    // NOTE: every variable assigned here gets a value before any branch, so no latch is inferred.
    always_comb begin
        acc      = crc_word_t'(lfsr_i);
        data_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            data_bit = REFLECT_IN ? data_i[i] : data_i[DATA_W-1-i];
            acc      = crc_step(acc, data_bit, CRC_W, crc_word_t'(POLY));
        end
        lfsr_o = CRC_W'(acc);
    end

endmodule

// File: rtl/crc_stream.sv
// Framed valid/ready CRC engine: frame FSM, LFSR register and registered result port.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               CRC_W       = 16,
    parameter logic [CRC_W-1:0] POLY        = 16'h1021,
    parameter logic [CRC_W-1:0] SEED        = '1,
    parameter int               DATA_W      = 8,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter logic [CRC_W-1:0] XOR_OUT     = '0,
    parameter logic [CRC_W-1:0] RESIDUE     = '0
) (
    input logic         clk,
    input logic         rst,
    crc_stream_if.slave s
);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic             crc_valid_q, crc_valid_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_match_q, crc_match_d;
    logic             frame_err_q, frame_err_d;

    logic             in_ready;
    logic             accept;
    logic [CRC_W-1:0] base_lfsr;
    logic [CRC_W-1:0] next_lfsr;
    crc_word_t        rev_word;
    logic [CRC_W-1:0] final_crc;

    assign in_ready = !rst && (state_q != HOLD);
    assign accept   = s.in_valid && in_ready;

    // A start-of-frame beat always begins from SEED, even when it aborts a frame in flight.
    assign base_lfsr = s.in_sop ? SEED : lfsr_q;

    crc_next_comb #(
        .CRC_W      (CRC_W),
        .POLY       (POLY),
        .DATA_W     (DATA_W),
        .REFLECT_IN (REFLECT_IN)
    ) u_next (
        .lfsr_i (base_lfsr),
        .data_i (s.in_data),
        .lfsr_o (next_lfsr)
    );

    always_comb begin
        rev_word  = bitrev(crc_word_t'(next_lfsr), CRC_W);
        final_crc = (REFLECT_OUT ? CRC_W'(rev_word) : next_lfsr) ^ XOR_OUT;
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        crc_valid_d = crc_valid_q;
        crc_out_d   = crc_out_q;
        crc_match_d = crc_match_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s.in_sop) begin
                        lfsr_d  = next_lfsr;
                        state_d = s.in_eop ? HOLD : ACCUM;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    lfsr_d      = next_lfsr;
                    frame_err_d = s.in_sop;
                    if (s.in_eop) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (s.crc_ready) begin
                    state_d     = IDLE;
                    lfsr_d      = SEED;
                    crc_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is captured once, on the edge that enters HOLD, and then held stable.
        if (state_d == HOLD && state_q != HOLD) begin
            crc_valid_d = 1'b1;
            crc_out_d   = final_crc;
            crc_match_d = (next_lfsr == RESIDUE);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            crc_valid_q <= 1'b0;
            crc_out_q   <= '0;
            crc_match_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            crc_valid_q <= crc_valid_d;
            crc_out_q   <= crc_out_d;
            crc_match_q <= crc_match_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s.in_ready  = in_ready;
    assign s.crc_valid = crc_valid_q;
    assign s.crc_out   = crc_out_q;
    assign s.crc_match = crc_match_q;
    assign s.frame_err = frame_err_q;

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench: CRC-16/CCITT-FALSE instance (a) and reflected CRC-32 instance (b).
module tb_crc_stream;

    typedef struct {
        logic [31:0] crc;
        logic        match;
    } exp_t;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_stream_if #(.DATA_W(8), .CRC_W(16)) if_a ();
    crc_stream_if #(.DATA_W(8), .CRC_W(32)) if_b ();

    crc_stream u_a (
        .clk (clk),
        .rst (rst),
        .s   (if_a)
    );

    crc_stream #(
        .CRC_W       (32),
        .POLY        (32'h04C11DB7),
        .SEED        (32'hFFFFFFFF),
        .DATA_W      (8),
        .REFLECT_IN  (1'b1),
        .REFLECT_OUT (1'b1),
        .XOR_OUT     (32'hFFFFFFFF),
        .RESIDUE     (32'h0)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .s   (if_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;
    int   err_seen_a = 0;
    int   err_seen_b = 0;
    int   err_exp_a = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: textbook MSB-first CRC-16, message byte folded into the top of the register.
    function automatic exp_t ref_a(input bq_t m);
        logic [15:0] crc;
        exp_t        e;
        crc = 16'hFFFF;
        foreach (m[k]) begin
            crc = crc ^ {m[k], 8'h00};
            for (int b = 0; b < 8; b++) begin
                crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
            end
        end
        e.crc   = {16'h0, crc};
        e.match = (crc == 16'h0);
        return e;
    endfunction

    // Reference: right-shifting reflected CRC-32 with the reversed polynomial.
    function automatic exp_t ref_b(input bq_t m);
        logic [31:0] crc;
        exp_t        e;
        crc = 32'hFFFFFFFF;
        foreach (m[k]) begin
            crc = crc ^ {24'h0, m[k]};
            for (int b = 0; b < 8; b++) begin
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
            end
        end
        e.crc   = crc ^ 32'hFFFFFFFF;
        e.match = (crc == 32'h0);
        return e;
    endfunction

    task automatic drive(input int which, input logic v, input logic [7:0] d,
                         input logic sop, input logic eop);
        if (which == 0) begin
            if_a.in_valid = v; if_a.in_data = d; if_a.in_sop = sop; if_a.in_eop = eop;
        end else begin
            if_b.in_valid = v; if_b.in_data = d; if_b.in_sop = sop; if_b.in_eop = eop;
        end
    endtask

    // Returns #1 after the edge that accepted the beat.
    task automatic send(input int which, input logic [7:0] d, input logic sop, input logic eop);
        int n;
        bit rdy;
        n = 0;
        @(negedge clk);
        drive(which, 1'b1, d, sop, eop);
        while (1) begin
            rdy = (which == 0) ? if_a.in_ready : if_b.in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
            #1;
        end
        #1;
        drive(which, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int which, input bq_t m, input int gap_max);
        foreach (m[k]) begin
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            send(which, m[k], k == 0, k == m.size() - 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 64'd0, 64'd1);
        #1;
    endtask

    // Monitor: pops the scoreboard on every result handshake and counts error pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (if_a.frame_err) err_seen_a++;
            if (if_b.frame_err) err_seen_b++;
            if (if_a.crc_valid && if_a.crc_ready) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q_a.pop_front();
                    check("a_crc_out", 64'(if_a.crc_out), 64'(e.crc));
                    check("a_crc_match", 64'(if_a.crc_match), 64'(e.match));
                end
            end
            if (if_b.crc_valid && if_b.crc_ready) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q_b.pop_front();
                    check("b_crc_out", 64'(if_b.crc_out), 64'(e.crc));
                    check("b_crc_match", 64'(if_b.crc_match), 64'(e.match));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                if_a.crc_ready = ($urandom_range(0, 3) != 0);
                if_b.crc_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        bq_t  msg;
        bq_t  m;
        exp_t e;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        if_a.crc_ready = 1'b1;
        if_b.crc_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready_low", 64'(if_a.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_crc_valid", 64'(if_a.crc_valid), 64'd0);
        check("rst_crc_out", 64'(if_a.crc_out), 64'd0);
        check("rst_crc_match", 64'(if_a.crc_match), 64'd0);
        check("rst_frame_err", 64'(if_a.frame_err), 64'd0);
        check("rst_in_ready_high", 64'(if_a.in_ready), 64'd1);
        check("rst_b_in_ready", 64'(if_b.in_ready), 64'd1);

        // Check value for "123456789"
        e.crc = 32'h29B1; e.match = 1'b0;
        q_a.push_back(e);
        send_frame(0, msg, 0);
        check("latency_valid", 64'(if_a.crc_valid), 64'd1);
        check("latency_out", 64'(if_a.crc_out), 64'h29B1);
        check("hold_in_ready", 64'(if_a.in_ready), 64'd0);

        // Appending the CRC bytes leaves the residue
        m = msg; m.push_back(8'h29); m.push_back(8'hB1);
        e.crc = 32'h0; e.match = 1'b1;
        q_a.push_back(e);
        send_frame(0, m, 1);

        e.crc = 32'hCBF43926; e.match = 1'b0;
        q_b.push_back(e);
        send_frame(1, msg, 0);
        check("b_latency_out", 64'(if_b.crc_out), 64'hCBF43926);
        drain();

        // Backpressure on the result port
        if_a.crc_ready = 1'b0;
        m = '{8'h31};
        e = ref_a(m);
        q_a.push_back(e);
        send(0, 8'h31, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(if_a.crc_valid), 64'd1);
            check("stall_out", 64'(if_a.crc_out), 64'(e.crc));
            check("stall_in_ready", 64'(if_a.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        if_a.crc_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 64'(if_a.in_ready), 64'd1);
        check("release_valid", 64'(if_a.crc_valid), 64'd0);

        // Beat without sop in IDLE
        send(0, 8'h55, 1'b0, 1'b0);
        err_exp_a++;
        check("idle_err_pulse", 64'(if_a.frame_err), 64'd1);
        check("idle_err_no_valid", 64'(if_a.crc_valid), 64'd0);
        @(posedge clk);
        #1;
        check("idle_err_one_cycle", 64'(if_a.frame_err), 64'd0);
        check("idle_err_still_idle", 64'(if_a.in_ready), 64'd1);

        // Restart mid-frame
        send(0, 8'h31, 1'b1, 1'b0);
        send(0, 8'h32, 1'b0, 1'b0);
        e.crc = 32'h29B1; e.match = 1'b0;
        q_a.push_back(e);
        err_exp_a++;
        send_frame(0, msg, 0);
        drain();

        // Reset mid-frame drops the partial frame
        for (int k = 0; k < 4; k++) send(0, msg[k], k == 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(if_a.in_ready), 64'd0);
        @(negedge clk);
        check("midrst_valid", 64'(if_a.crc_valid), 64'd0);
        rst = 1'b0;
        e.crc = 32'h29B1; e.match = 1'b0;
        q_a.push_back(e);
        send_frame(0, msg, 0);
        drain();

        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            m = {};
            repeat ($urandom_range(1, 12)) m.push_back(8'($urandom));
            q_a.push_back(ref_a(m));
            send_frame(0, m, 2);
        end
        for (int f = 0; f < 12; f++) begin
            m = {};
            repeat ($urandom_range(1, 10)) m.push_back(8'($urandom));
            q_b.push_back(ref_b(m));
            send_frame(1, m, 2);
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #3;
        if_a.crc_ready = 1'b1;
        if_b.crc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("a_frame_err_count", 64'(err_seen_a), 64'(err_exp_a));
        check("b_frame_err_count", 64'(err_seen_b), 64'd0);
        check("a_queue_empty", 64'(q_a.size()), 64'd0);
        check("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised, byte/word-parallel CRC engine with framed valid/ready streaming input and a registered result port. Successor to the single-polynomial serial CRC-16 LFSR, generalised in CRC width, polynomial, seed, data width per cycle, bit reflection and final XOR, and extended with frame delimiting, backpressure and a receive-side residue check. Sits between a packet source or sink and the framing logic; one instance per stream.

## Interface
- CRC_W, 16: CRC width in bits; legal range 8..64.
- POLY, 16'h1021: generator polynomial, implicit x^CRC_W term omitted.
- SEED, all ones: LFSR value loaded at reset and at each frame start.
- DATA_W, 8: input bits consumed per accepted beat; legal range 1..64.
- REFLECT_IN, 0: 1 = feed `in_data` bit 0 first; 0 = MSB first.
- REFLECT_OUT, 0: 1 = bit-reverse the LFSR before the final XOR.
- XOR_OUT, 0: value XORed onto the reported CRC.
- RESIDUE, 0: raw LFSR value indicating a good frame when CRC bytes are included.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present.
- in_ready  out  1  engine accepts the beat.
- in_data  in  DATA_W  message bits.
- in_sop  in  1  first beat of frame.
- in_eop  in  1  last beat of frame.
- crc_valid  out  1  result available.
- crc_ready  in  1  result consumed.
- crc_out  out  CRC_W  final CRC.
- crc_match  out  1  raw LFSR equals RESIDUE at frame end.
- frame_err  out  1  one-cycle pulse: protocol violation.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Per-bit step: fb = lfsr[CRC_W-1] ^ bit; lfsr = (lfsr << 1) ^ (fb ? POLY : 0). A beat applies DATA_W consecutive steps in one cycle.
- States: IDLE, ACCUM, HOLD.
- IDLE: in_ready=1. Accepted beat with in_sop starts from SEED (not the current LFSR), goes to ACCUM, or to HOLD if in_eop on the same beat. Accepted beat without in_sop is discarded, frame_err pulses, and the state stays IDLE.
- ACCUM: in_ready=1. Each accepted beat updates the LFSR. in_eop goes to HOLD. A beat with in_sop restarts from SEED, pulses frame_err, and the old frame is discarded (in_sop+in_eop on that beat goes to HOLD).
- HOLD: in_ready=0. crc_valid=1 and crc_out/crc_match are stable. `crc_valid && crc_ready` goes to IDLE and loads the LFSR with SEED.
- crc_out = (REFLECT_OUT ? bitrev(lfsr) : lfsr) ^ XOR_OUT; crc_match = (lfsr == RESIDUE), both registered on entry to HOLD.
- All arithmetic is modulo-2 in CRC_W bits. There is no carry and no width growth.

## Timing
- Reset values: state IDLE, lfsr SEED, crc_valid 0, crc_out 0, crc_match 0, frame_err 0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Throughput: one beat per cycle in ACCUM, no stalls.
- Latency: crc_valid rises the cycle after the in_eop beat is accepted.
- Bubble: in_ready drops for the HOLD cycles. The earliest next sop is accepted the cycle after the crc handshake.
- in_valid is ignored in HOLD. The source must hold the beat, per valid/ready rules.
- rst mid-frame or in HOLD: the frame and any pending result are dropped; values return to reset on the next edge.
- frame_err is high for exactly one cycle per violating beat.

## Structure
- Package `crc_pkg`:
  - state enum {IDLE, ACCUM, HOLD};
  - function `crc_step(lfsr, bit)`, parametrised on width and poly;
  - function `bitrev`.
- Sub-module `crc_next_comb`: combinational DATA_W-step unroll (lfsr, data, REFLECT_IN → next lfsr). It is unit-testable in isolation.
- Top holds the FSM, LFSR register and output registers.

## Test plan
- Defaults, DATA_W=8, ASCII "123456789" as 9 beats (sop on '1', eop on '9'), crc_ready=1 → crc_out=16'h29B1 one cycle after the last beat, crc_match=0.
- Defaults, "123456789" then 8'h29, 8'hB1 → crc_match=1 (RESIDUE 0).
- CRC_W=32, POLY=32'h04C11DB7, SEED=32'hFFFFFFFF, REFLECT_IN=REFLECT_OUT=1, XOR_OUT=32'hFFFFFFFF, DATA_W=32, "123456789" in 3 beats with the last beat padded → build variant DATA_W=8 gives crc_out=32'hCBF43926.
- SEED=0, single beat 8'h31 with sop+eop → crc_out=16'h2672 next cycle. Hold crc_ready=0 for 5 cycles → crc_valid and crc_out stay stable and in_ready=0; after release, in_ready=1 the following cycle.
- Beat without sop in IDLE → frame_err one-cycle pulse, no crc_valid. A second sop mid-frame before "123456789" → frame_err pulse, then crc_out=16'h29B1.
- rst asserted for one cycle after 4 beats of a frame, then full "123456789" frame → crc_out=16'h29B1, with no stale crc_valid.
